time_keeper: RTL and testbench

Parametrised real-time clock core for the term-project clock: it counts hours, minutes, seconds and hundredths in packed BCD from the system clock and drives the display path through `TIME_DATA`. It succeeds the fixed clock-mode block. It adds a configurable input frequency, run/stop, validated time loading, per-field increment for button setting, and a selectable 12/24-hour output with a PM flag.

---
 rtl/time_keeper.sv | 167 ++++++++++++++++
 tb/tb_time_keeper.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Real-time clock core: HH:MM:SS.hh in packed BCD, advanced from a CLK_FREQ/100 prescaler,
// with run/stop, validated loading, per-field increment and 12/24-hour display formatting.
module time_keeper #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        MODE_12H,
    input  logic        LOAD,
    input  logic [23:0] LOAD_DATA,
    input  logic        INC,
    input  logic [1:0]  INC_SEL,
    output logic [31:0] TIME_DATA,
    output logic        PM,
    output logic        SEC_TICK,
    output logic        LOAD_ERR
);

    localparam int DIV     = CLK_FREQ / 100;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);

    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2,
        SEL_HUND = 2'd3
    } inc_sel_e;

    logic [7:0]         hour_q, hour_d;
    logic [7:0]         min_q,  min_d;
    logic [7:0]         sec_q,  sec_d;
    logic [7:0]         hund_q, hund_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sec_tick_q, sec_tick_d;
    logic               load_err_q, load_err_d;

    logic               presc_wrap;
    logic               load_valid;
    logic [7:0]         hour_disp;
    inc_sel_e           inc_field;

    // Increment a two-digit BCD value, wrapping to 00 once it has reached lim.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    assign presc_wrap = RUN && (presc_q == PRESC_LAST);
    assign load_valid = bcd_ok(LOAD_DATA[23:16], 8'h23) &&
                        bcd_ok(LOAD_DATA[15:8],  8'h59) &&
                        bcd_ok(LOAD_DATA[7:0],   8'h59);
    assign inc_field  = inc_sel_e'(INC_SEL);

    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        hund_d     = hund_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;

        if (!RUN) begin
            presc_d = presc_q;
        end else if (presc_wrap) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        // Strobes win over the tick; a tick landing on a strobe cycle is simply dropped.
        if (LOAD) begin
            if (load_valid) begin
                hour_d  = LOAD_DATA[23:16];
                min_d   = LOAD_DATA[15:8];
                sec_d   = LOAD_DATA[7:0];
                hund_d  = 8'h00;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (INC) begin
            case (inc_field)
                SEL_SEC:  sec_d  = bcd_inc(sec_q,  8'h59);
                SEL_MIN:  min_d  = bcd_inc(min_q,  8'h59);
                SEL_HOUR: hour_d = bcd_inc(hour_q, 8'h23);
                SEL_HUND: begin
                    hund_d  = 8'h00;
                    presc_d = '0;
                end
                default: ;
            endcase
        end else if (presc_wrap) begin
            hund_d = bcd_inc(hund_q, 8'h99);
            if (hund_q == 8'h99) begin
                sec_d      = bcd_inc(sec_q, 8'h59);
                sec_tick_d = 1'b1;
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) begin
                        hour_d = bcd_inc(hour_q, 8'h23);
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hour_q     <= 8'h00;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            hund_q     <= 8'h00;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            hund_q     <= hund_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
        end
    end

    // 12-hour display: 00 shows as 12, 13..23 drop by twelve while staying in BCD.
    always_comb begin
        hour_disp = hour_q;
        if (MODE_12H) begin
            case (hour_q)
                8'h00:   hour_disp = 8'h12;
                8'h13:   hour_disp = 8'h01;
                8'h14:   hour_disp = 8'h02;
                8'h15:   hour_disp = 8'h03;
                8'h16:   hour_disp = 8'h04;
                8'h17:   hour_disp = 8'h05;
                8'h18:   hour_disp = 8'h06;
                8'h19:   hour_disp = 8'h07;
                8'h20:   hour_disp = 8'h08;
                8'h21:   hour_disp = 8'h09;
                8'h22:   hour_disp = 8'h10;
                8'h23:   hour_disp = 8'h11;
                default: hour_disp = hour_q;
            endcase
        end
    end

    assign TIME_DATA = {hour_disp, min_q, sec_q, hund_q};
    assign PM        = MODE_12H && (hour_q >= 8'h12);
    assign SEC_TICK  = sec_tick_q;
    assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: one instance at DIV=1 for fast wrap tests, one at DIV=10
// for prescaler and run/stop timing; both share the same stimulus.
module tb_time_keeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mode_12h;
    logic        load;
    logic [23:0] load_data;
    logic        inc;
    logic [1:0]  inc_sel;

    logic [31:0] f_time, s_time;
    logic        f_pm, s_pm;
    logic        f_tick, s_tick;
    logic        f_err, s_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    time_keeper #(.CLK_FREQ(100)) dut_fast (
        .CLK(clk), .RESET(rst_n), .RUN(run), .MODE_12H(mode_12h),
        .LOAD(load), .LOAD_DATA(load_data), .INC(inc), .INC_SEL(inc_sel),
        .TIME_DATA(f_time), .PM(f_pm), .SEC_TICK(f_tick), .LOAD_ERR(f_err)
    );

    time_keeper #(.CLK_FREQ(1000)) dut_slow (
        .CLK(clk), .RESET(rst_n), .RUN(run), .MODE_12H(mode_12h),
        .LOAD(load), .LOAD_DATA(load_data), .INC(inc), .INC_SEL(inc_sel),
        .TIME_DATA(s_time), .PM(s_pm), .SEC_TICK(s_tick), .LOAD_ERR(s_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        run = 1'b1;
        mode_12h = 1'b0;
        repeat (25) step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (f_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL reset_24h_fast: got %h expected 00000000", f_time);
        end
        n_cmp++;
        if (s_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL reset_24h_slow: got %h expected 00000000", s_time);
        end
        n_cmp++;
        if ({f_tick, f_err, s_tick, s_err} !== 4'b0000) begin
            n_bad++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {f_tick, f_err, s_tick, s_err});
        end
        mode_12h = 1'b1;
        #1;
        n_cmp++;
        if ({f_time, f_pm} !== {32'h12000000, 1'b0}) begin
            n_bad++; $display("[TB] FAIL reset_12h: got %h pm=%b expected 12000000 pm=0", f_time, f_pm);
        end
        mode_12h = 1'b0;
        run = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_midnight();
        int ticks = 0;
        step();
        load = 1'b1;
        load_data = 24'h235959;
        step();
        load = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (f_tick) ticks++;
            if (i == 99) begin
                n_cmp++;
                if ({f_time, f_tick} !== {32'h23595999, 1'b0}) begin
                    n_bad++; $display("[TB] FAIL midnight_pre: got %h tick=%b expected 23595999 tick=0", f_time, f_tick);
                end
            end
            if (i == 100) begin
                n_cmp++;
                if ({f_time, f_tick} !== {32'h00000000, 1'b1}) begin
                    n_bad++; $display("[TB] FAIL midnight_wrap: got %h tick=%b expected 00000000 tick=1", f_time, f_tick);
                end
            end
        end
        run = 1'b0;
        n_cmp++;
        if (ticks !== 1) begin
            n_bad++; $display("[TB] FAIL midnight_tick_count: got %0d expected 1", ticks);
        end
    endtask

    task automatic test_invalid_load();
        load = 1'b1;
        load_data = 24'h102030;
        step();
        n_cmp++;
        if ({f_time, f_err} !== {32'h10203000, 1'b0}) begin
            n_bad++; $display("[TB] FAIL load_valid: got %h err=%b expected 10203000 err=0", f_time, f_err);
        end
        load_data = 24'h245900;
        step();
        n_cmp++;
        if ({f_time, f_err} !== {32'h10203000, 1'b1}) begin
            n_bad++; $display("[TB] FAIL load_bad_hour: got %h err=%b expected 10203000 err=1", f_time, f_err);
        end
        load_data = 24'h12A000;
        step();
        n_cmp++;
        if ({f_time, f_err} !== {32'h10203000, 1'b1}) begin
            n_bad++; $display("[TB] FAIL load_bad_nibble: got %h err=%b expected 10203000 err=1", f_time, f_err);
        end
        load = 1'b0;
        step();
        n_cmp++;
        if ({f_time, f_err} !== {32'h10203000, 1'b0}) begin
            n_bad++; $display("[TB] FAIL load_err_clear: got %h err=%b expected 10203000 err=0", f_time, f_err);
        end
    endtask

    task automatic test_12h();
        logic [23:0] hh_in  [4] = '{24'h130502, 24'h230000, 24'h120000, 24'h200000};
        logic [31:0] hh_exp [4] = '{32'h01050200, 32'h11000000, 32'h12000000, 32'h08000000};
        for (int i = 0; i < 4; i++) begin
            load = 1'b1;
            load_data = hh_in[i];
            mode_12h = 1'b1;
            step();
            load = 1'b0;
            n_cmp++;
            if ({f_time, f_pm} !== {hh_exp[i], 1'b1}) begin
                n_bad++; $display("[TB] FAIL fmt12_%0d: got %h pm=%b expected %h pm=1", i, f_time, f_pm, hh_exp[i]);
            end
        end
        load = 1'b1;
        load_data = 24'h130502;
        step();
        load = 1'b0;
        mode_12h = 1'b0;
        #1;
        n_cmp++;
        if ({f_time, f_pm} !== {32'h13050200, 1'b0}) begin
            n_bad++; $display("[TB] FAIL fmt24: got %h pm=%b expected 13050200 pm=0", f_time, f_pm);
        end
        mode_12h = 1'b1;
        load = 1'b1;
        load_data = 24'h000000;
        step();
        load = 1'b0;
        n_cmp++;
        if ({f_time, f_pm} !== {32'h12000000, 1'b0}) begin
            n_bad++; $display("[TB] FAIL fmt12_midnight: got %h pm=%b expected 12000000 pm=0", f_time, f_pm);
        end
        mode_12h = 1'b0;
    endtask

    task automatic test_increment();
        int ticks = 0;
        load = 1'b1;
        load_data = 24'h235959;
        step();
        load = 1'b0;
        inc = 1'b1;
        inc_sel = 2'd2;
        step();
        if (f_tick) ticks++;
        n_cmp++;
        if (f_time !== 32'h00595900) begin
            n_bad++; $display("[TB] FAIL inc_hour_wrap: got %h expected 00595900", f_time);
        end
        inc_sel = 2'd1;
        step();
        if (f_tick) ticks++;
        n_cmp++;
        if (f_time !== 32'h00005900) begin
            n_bad++; $display("[TB] FAIL inc_min_wrap: got %h expected 00005900", f_time);
        end
        inc_sel = 2'd0;
        step();
        if (f_tick) ticks++;
        n_cmp++;
        if (f_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL inc_sec_wrap: got %h expected 00000000", f_time);
        end
        inc = 1'b0;
        load = 1'b1;
        load_data = 24'h090209;
        step();
        load = 1'b0;
        inc = 1'b1;
        inc_sel = 2'd0;
        step();
        if (f_tick) ticks++;
        inc_sel = 2'd2;
        step();
        if (f_tick) ticks++;
        inc = 1'b0;
        n_cmp++;
        if (f_time !== 32'h10021000) begin
            n_bad++; $display("[TB] FAIL inc_digit_carry: got %h expected 10021000", f_time);
        end
        n_cmp++;
        if (ticks !== 0) begin
            n_bad++; $display("[TB] FAIL inc_no_tick: got %0d ticks expected 0", ticks);
        end
    endtask

    task automatic test_prescaler_run();
        mode_12h = 1'b0;
        run = 1'b0;
        step();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        run = 1'b1;
        repeat (9) step();
        n_cmp++;
        if (s_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL presc_edge9: got %h expected 00000000", s_time);
        end
        step();
        n_cmp++;
        if (s_time !== 32'h00000001) begin
            n_bad++; $display("[TB] FAIL presc_edge10: got %h expected 00000001", s_time);
        end
        repeat (4) step();
        run = 1'b0;
        repeat (7) step();
        n_cmp++;
        if (s_time !== 32'h00000001) begin
            n_bad++; $display("[TB] FAIL run_hold: got %h expected 00000001", s_time);
        end
        run = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (s_time !== 32'h00000001) begin
            n_bad++; $display("[TB] FAIL resume_5: got %h expected 00000001", s_time);
        end
        step();
        n_cmp++;
        if (s_time !== 32'h00000002) begin
            n_bad++; $display("[TB] FAIL resume_6: got %h expected 00000002", s_time);
        end
    endtask

    task automatic test_clear_hundredths();
        repeat (3) step();
        inc = 1'b1;
        inc_sel = 2'd3;
        step();
        inc = 1'b0;
        n_cmp++;
        if (s_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL clr_hund: got %h expected 00000000", s_time);
        end
        repeat (9) step();
        n_cmp++;
        if (s_time !== 32'h00000000) begin
            n_bad++; $display("[TB] FAIL clr_presc_9: got %h expected 00000000", s_time);
        end
        step();
        n_cmp++;
        if (s_time !== 32'h00000001) begin
            n_bad++; $display("[TB] FAIL clr_presc_10: got %h expected 00000001", s_time);
        end
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        mode_12h = 1'b0;
        load = 1'b0;
        load_data = 24'h0;
        inc = 1'b0;
        inc_sel = 2'd0;
        #12 rst_n = 1'b1;
        $display("[TB] starting time_keeper tests");
        test_reset();
        test_midnight();
        test_invalid_load();
        test_12h();
        test_increment();
        test_prescaler_run();
        test_clear_hundredths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
